adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_adder_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one multi-cycle floating-point adder between two requesters.
//   A requester raises rqX_stb with its operands; the arbiter grants one
//   requester (round-robin on ties), hands the operands to the adder, waits
//   for add_ready (bounded by TIMEOUT cycles), returns the sum on
//   rqX_result/rqX_ready and waits for rqX_ack before going idle again.
//   A timed-out add returns a quiet NaN and sets the sticky err flag.
//
// Ports
//   clk, reset                : clock (rising edge), asynchronous active-low reset
//   rq0_stb/rq1_stb           : operands valid, held until accepted
//   rq0_a,rq0_b/rq1_a,rq1_b   : requester operands
//   rq0_accept/rq1_accept     : one-cycle pulse when operands are captured
//   rq0_ready/rq1_ready       : result valid, held until the matching ack
//   rq0_result/rq1_result     : per-requester result registers
//   rq0_ack/rq1_ack           : requester consumed its result
//   add_load, add_a, add_b    : start pulse and operands to the shared adder
//   add_ack                   : result taken from the adder
//   add_ready, add_result     : adder response
//   err                       : sticky timeout flag, cleared only by reset
module adder_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_stb,
    input  logic [DATA_W-1:0] rq0_a,
    input  logic [DATA_W-1:0] rq0_b,
    output logic              rq0_accept,
    output logic              rq0_ready,
    output logic [DATA_W-1:0] rq0_result,
    input  logic              rq0_ack,
    input  logic              rq1_stb,
    input  logic [DATA_W-1:0] rq1_a,
    input  logic [DATA_W-1:0] rq1_b,
    output logic              rq1_accept,
    output logic              rq1_ready,
    output logic [DATA_W-1:0] rq1_result,
    input  logic              rq1_ack,
    output logic              add_load,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_ack,
    input  logic              add_ready,
    input  logic [DATA_W-1:0] add_result,
    output logic              err
);

    localparam int unsigned       CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] QNAN     = DATA_W'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DELIVER
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;     // 0: rq0 owns the adder, 1: rq1
    logic              last_q, last_d;       // requester served last
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] add_a_q, add_a_d;
    logic [DATA_W-1:0] add_b_q, add_b_d;
    logic [DATA_W-1:0] res0_q, res0_d;
    logic [DATA_W-1:0] res1_q, res1_d;
    logic              err_q, err_d;
    logic              acc0_q, acc0_d;
    logic              acc1_q, acc1_d;
    logic              load_q, load_d;
    logic              ack_q, ack_d;
    logic              rdy0_q, rdy0_d;
    logic              rdy1_q, rdy1_d;
    logic              pick;
    logic              granted_ack;

    // All outputs are registered, so each state's outputs appear one cycle
    // after the state is entered: accept shows during LOAD, add_load during
    // the first WAIT cycle, ready during the first DELIVER cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res0_d      = res0_q;
        res1_d      = res1_q;
        err_d       = err_q;
        acc0_d      = 1'b0;
        acc1_d      = 1'b0;
        load_d      = 1'b0;
        ack_d       = ack_q;
        rdy0_d      = rdy0_q;
        rdy1_d      = rdy1_q;
        pick        = 1'b0;
        granted_ack = grant_q ? rq1_ack : rq0_ack;

        case (state_q)
            ST_IDLE: begin
                if (rq0_stb || rq1_stb) begin
                    // Tie goes to the requester not served last.
                    pick    = (rq0_stb && rq1_stb) ? ~last_q : rq1_stb;
                    grant_d = pick;
                    add_a_d = pick ? rq1_a : rq0_a;
                    add_b_d = pick ? rq1_b : rq0_b;
                    acc0_d  = ~pick;
                    acc1_d  = pick;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_d  = 1'b1;
                ack_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (add_ready) begin
                    if (grant_q) begin
                        res1_d = add_result;
                        rdy1_d = 1'b1;
                    end else begin
                        res0_d = add_result;
                        rdy0_d = 1'b1;
                    end
                    ack_d   = 1'b1;
                    state_d = ST_DELIVER;
                end else if (cnt_q == CNT_LAST) begin
                    if (grant_q) begin
                        res1_d = QNAN;
                        rdy1_d = 1'b1;
                    end else begin
                        res0_d = QNAN;
                        rdy0_d = 1'b1;
                    end
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (granted_ack) begin
                    rdy0_d  = 1'b0;
                    rdy1_d  = 1'b0;
                    ack_d   = 1'b0;
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            err_q   <= 1'b0;
            acc0_q  <= 1'b0;
            acc1_q  <= 1'b0;
            load_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            err_q   <= err_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
        end
    end

    assign rq0_accept = acc0_q;
    assign rq1_accept = acc1_q;
    assign rq0_ready  = rdy0_q;
    assign rq1_ready  = rdy1_q;
    assign rq0_result = res0_q;
    assign rq1_result = res1_q;
    assign add_load   = load_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_ack    = ack_q;
    assign err        = err_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
//   Directed bench for adder_arbiter with a behavioural adder of
//   programmable latency. Expected sums are queued per requester when a
//   request is raised and compared when that requester's ready rises.
module tb_adder_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rq0_stb = 1'b0, rq1_stb = 1'b0;
    logic [DW-1:0] rq0_a = '0, rq0_b = '0, rq1_a = '0, rq1_b = '0;
    logic          rq0_accept, rq1_accept, rq0_ready, rq1_ready;
    logic [DW-1:0] rq0_result, rq1_result;
    logic          rq0_ack = 1'b0, rq1_ack = 1'b0;
    logic          add_load, add_ack;
    logic [DW-1:0] add_a, add_b;
    logic          add_ready;
    logic [DW-1:0] add_result;
    logic          err;

    int            errors = 0;
    int            checks = 0;
    int            acc0_cnt = 0;
    int            load_cnt = 0;
    logic [31:0]   q0[$];
    logic [31:0]   q1[$];

    int            add_lat = 3;
    bit            adder_dead = 1'b0;
    int            left;
    logic [31:0]   pend;
    logic          prev_r0 = 1'b0, prev_r1 = 1'b0;

    adder_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rq0_stb    (rq0_stb),
        .rq0_a      (rq0_a),
        .rq0_b      (rq0_b),
        .rq0_accept (rq0_accept),
        .rq0_ready  (rq0_ready),
        .rq0_result (rq0_result),
        .rq0_ack    (rq0_ack),
        .rq1_stb    (rq1_stb),
        .rq1_a      (rq1_a),
        .rq1_b      (rq1_b),
        .rq1_accept (rq1_accept),
        .rq1_ready  (rq1_ready),
        .rq1_result (rq1_result),
        .rq1_ack    (rq1_ack),
        .add_load   (add_load),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_ack    (add_ack),
        .add_ready  (add_ready),
        .add_result (add_result),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Known single-precision sums used by the stimulus.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
            {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
            {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000;
            {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000;
            {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Adder model: add_ready rises add_lat cycles after the add_load cycle,
    // drops once add_ack is seen.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_ready  <= 1'b0;
            add_result <= '0;
            left       <= 0;
            pend       <= '0;
        end else begin
            if (add_load && !adder_dead) begin
                if (add_lat <= 1) begin
                    add_ready  <= 1'b1;
                    add_result <= fadd(add_a, add_b);
                    left       <= 0;
                end else begin
                    left <= add_lat - 1;
                    pend <= fadd(add_a, add_b);
                end
            end else if (left > 1) begin
                left <= left - 1;
            end else if (left == 1) begin
                left       <= 0;
                add_ready  <= 1'b1;
                add_result <= pend;
            end
            if (add_ack) add_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard and protocol monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (rq0_accept) acc0_cnt++;
            if (add_load) load_cnt++;
            chk("ready_overlap", 32'(rq0_ready & rq1_ready), 32'd0);
            if (rq0_ready && !prev_r0) begin
                if (q0.size() == 0) chk("sb0_unexpected_ready", 32'(rq0_ready), 32'd0);
                else chk("sb_rq0_result", rq0_result, q0.pop_front());
            end
            if (rq1_ready && !prev_r1) begin
                if (q1.size() == 0) chk("sb1_unexpected_ready", 32'(rq1_ready), 32'd0);
                else chk("sb_rq1_result", rq1_result, q1.pop_front());
            end
        end
        prev_r0 = rq0_ready;
        prev_r1 = rq1_ready;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int which, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expv);
        if (which == 0) begin
            rq0_a = a; rq0_b = b; rq0_stb = 1'b1; q0.push_back(expv);
        end else begin
            rq1_a = a; rq1_b = b; rq1_stb = 1'b1; q1.push_back(expv);
        end
    endtask

    task automatic wait_accept(output int who, output int cyc);
        who = -1;
        cyc = 0;
        while (who < 0 && cyc < 20) begin
            tick();
            cyc++;
            if (rq0_accept) who = 0;
            else if (rq1_accept) who = 1;
        end
        chk("accept_seen", 32'(who >= 0), 32'd1);
        chk("accept_onehot", 32'(rq0_accept & rq1_accept), 32'd0);
    endtask

    // Requester drops stb once accepted; next cycle must carry the adder load.
    task automatic post_accept(input int which);
        if (which == 0) rq0_stb = 1'b0; else rq1_stb = 1'b0;
        tick();
        chk("load_pulse", 32'(add_load), 32'd1);
        chk("accept_one_cycle", 32'(rq0_accept | rq1_accept), 32'd0);
    endtask

    task automatic wait_ready(input int which, output int cyc);
        logic r;
        cyc = 0;
        do begin
            tick();
            cyc++;
            r = (which == 0) ? rq0_ready : rq1_ready;
        end while (!r && cyc < int'(TO) + 10);
        chk("ready_seen", 32'(r), 32'd1);
    endtask

    task automatic do_ack(input int which);
        if (which == 0) rq0_ack = 1'b1; else rq1_ack = 1'b1;
        tick();
        chk("ready_drop", 32'((which == 0) ? rq0_ready : rq1_ready), 32'd0);
        chk("add_ack_drop", 32'(add_ack), 32'd0);
        rq0_ack = 1'b0;
        rq1_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({rq0_accept, rq1_accept, rq0_ready, rq1_ready,
                                  add_load, add_ack, err}), 32'd0);
        chk({tag, "_res0"}, rq0_result, 32'd0);
        chk({tag, "_res1"}, rq1_result, 32'd0);
        chk({tag, "_add_a"}, add_a, 32'd0);
        chk({tag, "_add_b"}, add_b, 32'd0);
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who, c, acc_snap;

        // Reset state
        apply_reset();

        // Single rq0 transaction, adder latency 3
        add_lat = 3;
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        wait_accept(who, c);
        chk("t1_grant", 32'(who), 32'd0);
        chk("t1_accept_lat", 32'(c), 32'd1);
        post_accept(0);
        chk("t1_add_a", add_a, 32'h3F80_0000);
        chk("t1_add_b", add_b, 32'h4000_0000);
        tick();
        chk("t1_load_once", 32'(add_load), 32'd0);
        wait_ready(0, c);
        chk("t1_ready_lat", 32'(c), 32'd3);
        repeat (3) begin
            tick();
            chk("t1_ready_held", 32'(rq0_ready), 32'd1);
        end
        chk("t1_add_ack", 32'(add_ack), 32'd1);
        do_ack(0);
        chk("t1_result_hold", rq0_result, 32'h4040_0000);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_accept_count", 32'(acc0_cnt), 32'd1);
        chk("t1_load_count", 32'(load_cnt), 32'd1);

        // Round-robin with both requesters contending from reset
        apply_reset();
        add_lat = 2;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        set_req(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        for (int i = 0; i < 4; i++) begin
            wait_accept(who, c);
            chk("rr_grant", 32'(who), 32'(i % 2));
            chk("rr_accept_lat", 32'(c), 32'd1);
            post_accept(who);
            wait_ready(who, c);
            chk("rr_ready_lat", 32'(c), 32'd3);
            do_ack(who);
            if (i == 0) set_req(0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000);
            if (i == 1) set_req(1, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
        end

        // rq1 granted; rq0 arrives mid-WAIT and must wait for IDLE
        add_lat = 4;
        set_req(1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000);
        wait_accept(who, c);
        chk("mw_grant", 32'(who), 32'd1);
        post_accept(1);
        tick();
        acc_snap = acc0_cnt;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        wait_ready(1, c);
        chk("mw_no_early_accept", 32'(acc0_cnt), 32'(acc_snap));
        rq0_ack = 1'b1;
        tick();
        chk("mw_foreign_ack_ignored", 32'(rq1_ready), 32'd1);
        rq0_ack = 1'b0;
        rq1_ack = 1'b1;
        tick();
        chk("mw_rq1_drop", 32'(rq1_ready), 32'd0);
        chk("mw_idle_no_accept", 32'(rq0_accept), 32'd0);
        rq1_ack = 1'b0;
        tick();
        chk("mw_accept_after_idle", 32'(rq0_accept), 32'd1);
        post_accept(0);
        wait_ready(0, c);
        chk("mw_rq0_lat", 32'(c), 32'd5);
        do_ack(0);
        chk("mw_rq1_result_hold", rq1_result, 32'h4080_0000);

        // Adder answers in the very last WAIT cycle: normal result wins
        add_lat = int'(TO) - 1;
        set_req(0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000);
        wait_accept(who, c);
        post_accept(0);
        wait_ready(0, c);
        chk("edge_ready_lat", 32'(c), 32'(TO));
        chk("edge_err", 32'(err), 32'd0);
        do_ack(0);

        // Adder never answers: timeout NaN and sticky err
        adder_dead = 1'b1;
        set_req(0, 32'h4000_0000, 32'h4000_0000, 32'h7FC0_0000);
        wait_accept(who, c);
        post_accept(0);
        wait_ready(0, c);
        chk("to_ready_lat", 32'(c), 32'(TO));
        chk("to_err", 32'(err), 32'd1);
        chk("to_add_ack", 32'(add_ack), 32'd1);
        do_ack(0);
        adder_dead = 1'b0;
        add_lat = 1;
        set_req(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        wait_accept(who, c);
        chk("to_next_grant", 32'(who), 32'd1);
        post_accept(1);
        wait_ready(1, c);
        chk("to_next_lat", 32'(c), 32'd2);
        do_ack(1);
        chk("to_err_sticky", 32'(err), 32'd1);

        // Reset pulsed during WAIT
        add_lat = 3;
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        wait_accept(who, c);
        post_accept(0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        q0.delete();
        tick();
        tick();
        reset = 1'b1;
        repeat (6) begin
            tick();
            chk("post_reset_quiet", 32'({rq0_accept, rq1_accept, rq0_ready, rq1_ready,
                                         add_load, err}), 32'd0);
        end
        set_req(1, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
        wait_accept(who, c);
        chk("pr_grant", 32'(who), 32'd1);
        chk("pr_accept_lat", 32'(c), 32'd1);
        post_accept(1);
        wait_ready(1, c);
        chk("pr_ready_lat", 32'(c), 32'd4);
        do_ack(1);
        chk("pr_rq0_result_clear", rq0_result, 32'd0);
        chk("pr_err", 32'(err), 32'd0);

        tick();
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
